// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/response bundle for alu_pipe.
//   in_valid/in_ready  request handshake, carries a, b, ALUOp
//   out_valid/out_ready response handshake, carries Result, Zero, Overflow
//   master: request producer / result consumer
//   slave : the ALU itself
interface alu_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUOp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Overflow;

  modport master (
    output in_valid, a, b, ALUOp, out_ready,
    input  in_ready, out_valid, Result, Zero, Overflow
  );

  modport slave (
    input  in_valid, a, b, ALUOp, out_ready,
    output in_ready, out_valid, Result, Zero, Overflow
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with valid/ready handshakes on both sides.
// Non-MUL ops produce a registered result one cycle after acceptance; MUL
// runs a shift-add loop (one multiplier bit per cycle) and presents its
// result WIDTH cycles after acceptance. A presented result is held until
// the consumer takes it; a new request may be accepted in that same cycle.
//   clk   rising-edge clock
//   reset synchronous, active-high
//   bus   alu_pipe_if slave (request a/b/ALUOp, response Result/Zero/Overflow)
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | nothing presented, ready for a request
// MUL_BUSY | shift-add multiply in progress, requests stalled
// HOLD     | result presented, waiting for out_ready
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  alu_pipe_if.slave  bus
);
  localparam int SHAMT = $clog2(WIDTH);
  // Bit 0 of the multiplier is folded in on the accepting edge, so the
  // busy phase only walks the remaining WIDTH-1 bits.
  localparam logic [SHAMT-1:0] LAST_ITER = SHAMT'(WIDTH - 2);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [SHAMT-1:0] cnt_q;

  logic             in_ready_i;
  logic             accept;
  logic             is_mul;
  logic [SHAMT-1:0] shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] pp0;
  logic [WIDTH-1:0] mul_sum;

  logic             valid_nxt;
  logic             load_res;
  logic [WIDTH-1:0] res_nxt;
  logic             ovf_nxt;
  logic             mul_start;

  assign in_ready_i = !reset && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
  assign accept     = bus.in_valid && in_ready_i;
  assign is_mul     = (bus.ALUOp == OP_MUL);
  assign shamt      = bus.b[SHAMT-1:0];
  assign sum        = bus.a + bus.b;
  assign diff       = bus.a - bus.b;
  assign pp0        = bus.b[0] ? bus.a : '0;
  assign mul_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALUOp)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        // B is effectively inverted, so "signs match" becomes "signs differ".
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLL: alu_res = bus.a << shamt;
      OP_SRL: alu_res = bus.a >> shamt;
      OP_SRA: alu_res = $unsigned($signed(bus.a) >>> shamt);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_NOR: alu_res = ~(bus.a | bus.b);
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = out_valid_q;
    load_res  = 1'b0;
    res_nxt   = alu_res;
    ovf_nxt   = alu_ovf;
    mul_start = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_nxt = MUL_BUSY;
          end else begin
            load_res  = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      MUL_BUSY: begin
        if (cnt_q == LAST_ITER) begin
          load_res  = 1'b1;
          res_nxt   = mul_sum;
          ovf_nxt   = 1'b0;
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
          if (accept) begin
            if (is_mul) begin
              mul_start = 1'b1;
              state_nxt = MUL_BUSY;
            end else begin
              load_res  = 1'b1;
              valid_nxt = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= valid_nxt;
      if (load_res) begin
        res_q  <= res_nxt;
        zero_q <= (res_nxt == '0);
        ovf_q  <= ovf_nxt;
      end
      if (mul_start) begin
        acc_q    <= pp0;
        mcand_q  <= bus.a << 1;
        mplier_q <= bus.b >> 1;
        cnt_q    <= '0;
      end else if (state == MUL_BUSY) begin
        acc_q    <= mul_sum;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = res_q;
  assign bus.Zero      = zero_q;
  assign bus.Overflow  = ovf_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=64): a scoreboard queue filled at request
// acceptance from a behavioural model, drained by an independent monitor.
module tb_alu_pipe;
  localparam int W = 64;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   npass = 0;
  int   ntot = 0;
  bit   rand_or = 1'b0;
  exp_t q[$];
  int   pop_log[$];

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] wide;
    int sh;
    sh = int'(b[5:0]);
    e.r = '0;
    e.v = 1'b0;
    case (op)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: begin
        wide = {a[W-1], a} + {b[W-1], b};
        e.r = wide[W-1:0];
        e.v = wide[W] ^ wide[W-1];
      end
      4'b0110: begin
        wide = {a[W-1], a} - {b[W-1], b};
        e.r = wide[W-1:0];
        e.v = wide[W] ^ wide[W-1];
      end
      4'b0011: e.r = a << sh;
      4'b0100: e.r = a >> sh;
      4'b0101: begin
        e.r = a;
        for (int i = 0; i < sh; i++) e.r = {e.r[W-1], e.r[W-1:1]};
      end
      4'b0111: e.r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b1000: e.r = a ^ b;
      4'b1001: e.r = a * b;
      4'b1100: e.r = ~(a | b);
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitor: samples well away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.out_valid && bus.out_ready) begin
        pop_log.push_back(cyc);
        if (q.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_output: got result %h with no pending request", bus.Result);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", bus.Result, e.r);
          check("zero", {63'd0, bus.Zero}, {63'd0, e.z});
          check("overflow", {63'd0, bus.Overflow}, {63'd0, e.v});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rand_or) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d expected 0 remaining", q.size());
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit done;
    done = 1'b0;
    @(negedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.ALUOp = op;
    bus.a = a;
    bus.b = b;
    for (int t = 0; t < 500; t++) begin
      #1;
      if (bus.in_ready) begin
        q.push_back(model(op, a, b));
        done = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!done) begin
      ntot++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 500 cycles");
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      bus.ALUOp = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic drain();
    rand_or = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [3:0] nonmul_ops[10];
    logic [3:0] bad_ops[5];
    exp_t e_and;
    int bad;
    int k;
    nonmul_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                   4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1100};
    bad_ops = '{4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111};

    // Reset with a request pending: must not be accepted.
    bus.in_valid = 1'b1;
    bus.ALUOp = 4'b0010;
    bus.a = 64'd1;
    bus.b = 64'd1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_result", bus.Result, 64'd0);
    check("rst_zero", {63'd0, bus.Zero}, 64'd1);
    check("rst_overflow", {63'd0, bus.Overflow}, 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("ready_after_reset", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("no_accept_in_reset", {63'd0, bus.out_valid}, 64'd0);

    // Directed corner cases, out_ready held high.
    issue(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check("add_latency_valid", {63'd0, bus.out_valid}, 64'd1);
    check("add_ovf_result", bus.Result, 64'h8000_0000_0000_0000);
    check("add_ovf_flag", {63'd0, bus.Overflow}, 64'd1);
    issue(4'b0110, 64'd5, 64'd5);
    check("sub_zero_flag", {63'd0, bus.Zero}, 64'd1);
    issue(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("slt_result", bus.Result, 64'd1);
    issue(4'b0101, 64'h8000_0000_0000_0000, 64'h43);
    check("sra_result", bus.Result, 64'hF000_0000_0000_0000);
    issue(4'b0011, 64'd1, 64'd63);
    check("sll_result", bus.Result, 64'h8000_0000_0000_0000);
    issue(4'b1010, 64'h1234, 64'h5678);
    check("undef_zero", {63'd0, bus.Zero}, 64'd1);
    drain();

    // MUL latency and stall.
    issue(4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    bad = 0;
    k = 0;
    while (!bus.out_valid && k < 200) begin
      if (bus.in_ready) bad++;
      @(posedge clk);
      #1;
      k++;
    end
    check("mul_latency", 64'(k + 1), 64'd64);
    check("mul_in_ready_low", 64'(bad), 64'd0);
    check("mul_result", bus.Result, 64'hFFFF_FFFF_FFFF_FFFD);
    drain();

    // Backpressure on an AND result, then back-to-back throughput.
    bus.out_ready = 1'b0;
    e_and = model(4'b0000, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
    issue(4'b0000, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
    for (int i = 0; i < 5; i++) begin
      check("bp_result_stable", bus.Result, e_and.r);
      check("bp_valid_held", {63'd0, bus.out_valid}, 64'd1);
      check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    pop_log.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      issue(nonmul_ops[$urandom_range(0, 9)], {$urandom, $urandom}, {$urandom, $urandom});
    drain();
    check("b2b_count", 64'(pop_log.size()), 64'd11);
    bad = 0;
    for (int i = 1; i < pop_log.size(); i++)
      if (pop_log[i] - pop_log[i-1] != 1) bad++;
    check("b2b_gaps", 64'(bad), 64'd0);

    // Randomised traffic with random consumer backpressure.
    rand_or = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [3:0] op;
      logic [W-1:0] a, b;
      r = $urandom_range(0, 99);
      if (r < 8) op = 4'b1001;
      else if (r < 14) op = bad_ops[$urandom_range(0, 4)];
      else op = nonmul_ops[$urandom_range(0, 9)];
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: a = 64'h8000_0000_0000_0000;
        1: b = a;
        2: a = 64'h7FFF_FFFF_FFFF_FFFF;
        3: b = 64'($urandom_range(0, 70));
        default: ;
      endcase
      issue(op, a, b);
    end
    drain();

    // Reset in the middle of a multiply: result must never appear.
    issue(4'b1001, 64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321);
    repeat (18) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("abort_result", bus.Result, 64'd0);
    check("abort_zero", {63'd0, bus.Zero}, 64'd1);
    check("abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_ready_after", {63'd0, bus.in_ready}, 64'd1);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) bad++;
    end
    check("abort_no_stale", 64'(bad), 64'd0);
    issue(4'b0010, 64'd40, 64'd2);
    check("post_abort_add", bus.Result, 64'd42);
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width; SHALL be a power of two, 8 to 64.
REQ-002 Derived SHAMT = log2(WIDTH), shift-amount width; not overridable.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; b[SHAMT-1:0] is the shift amount.
REQ-009 ALUOp  input  4  operation select.
REQ-010 out_valid  output  1  Result/flags valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 Result  output  WIDTH  registered result.
REQ-013 Zero  output  1  registered; 1 when Result == 0.
REQ-014 Overflow  output  1  registered; signed overflow for ADD/SUB, 0 for all other ops.

Function
REQ-015 Encodings: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SRA 0101, SUB 0110, SLT 0111, XOR 1000, MUL 1001, NOR 1100.
REQ-016 Any other ALUOp: Result 0, Zero 1, Overflow 0, single-cycle latency.
REQ-017 ADD/SUB wrap modulo 2^WIDTH; Overflow = operand signs match (after B inversion for SUB) and result sign differs.
REQ-018 SLT: signed compare, Result = 1 if a < b, else 0.
REQ-019 SLL/SRL logical; SRA replicates a[WIDTH-1]; amount = b[SHAMT-1:0] only.
REQ-020 MUL: low WIDTH bits of a*b (sign-agnostic), via iterative shift-add, one multiplier bit per cycle; no combinational WIDTH x WIDTH multiplier.
REQ-021 Handshake transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-022 FSM states: IDLE, MUL_BUSY, HOLD.
REQ-023 IDLE: in_ready = 1. Accepted non-MUL op -> Result/flags registered, out_valid = 1 next cycle, go HOLD.
REQ-024 IDLE: accepted MUL -> latch a, b; go MUL_BUSY; iteration counter cleared.
REQ-025 MUL_BUSY: in_ready = 0; exactly WIDTH iterations; on last iteration write Result/flags, out_valid = 1, go HOLD. Accept-to-out_valid latency = WIDTH cycles.
REQ-026 Non-MUL accept-to-out_valid latency = 1 cycle.
REQ-027 HOLD: Result, Zero, Overflow, out_valid stable until out_ready.
REQ-028 HOLD with out_ready = 1: in_ready = 1 (pass-through); new request accepted same cycle; non-MUL result replaces old next cycle with out_valid staying 1; MUL goes MUL_BUSY with out_valid = 0.
REQ-029 HOLD with out_ready = 0: in_ready = 0.
REQ-030 out_ready while out_valid = 0 has no effect.
REQ-031 Operands a, b, ALUOp sampled only on input transfer; changes at other times ignored.
REQ-032 Zero/Overflow always describe the currently presented Result.
REQ-033 Throughput for back-to-back non-MUL ops with out_ready held 1: one result per cycle.

Reset
REQ-034 reset = 1 at rising edge: state IDLE, out_valid 0, Result 0, Zero 1, Overflow 0, MUL counter/accumulators 0.
REQ-035 Reset during MUL_BUSY or HOLD aborts; pending result discarded, never presented.
REQ-036 in_ready = 0 while reset asserted; requests during reset not accepted.
REQ-037 First accept possible in cycle after reset deasserts.

Verification
REQ-038 WIDTH=64, ADD a=0x7FFFFFFFFFFFFFFF, b=1, out_ready=1 -> 1 cycle later Result 0x8000000000000000, Overflow 1, Zero 0.
REQ-039 SUB a=5, b=5 -> Result 0, Zero 1, Overflow 0; SLT a=-1, b=1 -> Result 1.
REQ-040 SRA a=0x8000000000000000, b=0x43 (amount 3) -> Result 0xF000000000000000; SLL a=1, b=63 -> 0x8000000000000000.
REQ-041 MUL a=0xFFFFFFFFFFFFFFFF, b=3 -> in_ready 0 for 64 cycles, then Result 0xFFFFFFFFFFFFFFFD, out_valid 1 exactly 64 cycles after accept.
REQ-042 Backpressure: out_ready=0 for 5 cycles after AND result -> Result stable, in_ready 0; then 10 back-to-back ops with out_ready=1 -> 10 results in 10 consecutive cycles, in order.
REQ-043 Reset asserted mid-MUL (cycle 20) -> next cycle out_valid 0, Result 0, Zero 1, in_ready 1 after deassert; no stale result emitted.
